// File: rtl/elevator_scheduler.sv
// Collective (SCAN) elevator sequencer: walks the car floor by floor toward pending
// calls, opens the doors at called floors and requests a clear of the served call.
module elevator_scheduler #(
    parameter int unsigned NUM_FLOORS    = 8,
    parameter int unsigned TRAVEL_CYCLES = 4,
    parameter int unsigned DOOR_CYCLES   = 6
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] call_mask,
    input  logic       door_hold,
    output logic [2:0] floor,
    output logic       dir_up,
    output logic       moving,
    output logic       door_open,
    output logic       clr_en,
    output logic [2:0] clr_floor
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_MOVING = 2'd1;
    localparam logic [1:0] ST_ARRIVE = 2'd2;
    localparam logic [1:0] ST_DOORS  = 2'd3;

    localparam logic [7:0] TRAVEL_RELOAD = 8'(TRAVEL_CYCLES - 1);
    localparam logic [7:0] DOOR_RELOAD   = 8'(DOOR_CYCLES - 1);
    localparam logic [2:0] TOP_FLOOR     = 3'(NUM_FLOORS - 1);
    // Calls at floors that do not exist are ignored everywhere.
    localparam logic [7:0] VALID_MASK    = 8'((16'd1 << NUM_FLOORS) - 16'd1);

    logic [1:0] state_q, state_d;
    logic [2:0] floor_q, floor_d;
    logic       dir_up_q, dir_up_d;
    logic [7:0] timer_q, timer_d;
    logic       moving_q, door_open_q;

    logic [7:0] calls;
    logic       call_above, call_below, call_here, call_ahead;

    assign calls      = call_mask & VALID_MASK;
    assign call_here  = calls[floor_q];
    assign call_ahead = dir_up_q ? call_above : call_below;

    // Reduce the masked calls into above/below flags relative to the current floor.
    always_comb begin
        call_above = 1'b0;
        call_below = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (calls[i] && (i > int'(floor_q))) call_above = 1'b1;
            if (calls[i] && (i < int'(floor_q))) call_below = 1'b1;
        end
    end

    // SCAN next-state: keep direction while calls lie ahead, reverse only from IDLE.
    always_comb begin
        state_d  = state_q;
        floor_d  = floor_q;
        dir_up_d = dir_up_q;
        timer_d  = timer_q;
        case (state_q)
            ST_IDLE: begin
                if (call_here) begin
                    state_d = ST_DOORS;
                    timer_d = DOOR_RELOAD;
                end else if (call_ahead) begin
                    state_d = ST_MOVING;
                    timer_d = TRAVEL_RELOAD;
                end else if (call_above) begin
                    dir_up_d = 1'b1;
                    state_d  = ST_MOVING;
                    timer_d  = TRAVEL_RELOAD;
                end else if (call_below) begin
                    dir_up_d = 1'b0;
                    state_d  = ST_MOVING;
                    timer_d  = TRAVEL_RELOAD;
                end
            end
            ST_MOVING: begin
                if (timer_q == 8'd0) begin
                    // Saturating step; never leaves the served range.
                    if (dir_up_q) begin
                        if (floor_q != TOP_FLOOR) floor_d = floor_q + 3'd1;
                    end else begin
                        if (floor_q != 3'd0) floor_d = floor_q - 3'd1;
                    end
                    state_d = ST_ARRIVE;
                end else begin
                    timer_d = timer_q - 8'd1;
                end
            end
            ST_ARRIVE: begin
                if (call_here) begin
                    state_d = ST_DOORS;
                    timer_d = DOOR_RELOAD;
                end else if (call_ahead) begin
                    state_d = ST_MOVING;
                    timer_d = TRAVEL_RELOAD;
                end else begin
                    state_d = ST_IDLE;
                    timer_d = 8'd0;
                end
            end
            ST_DOORS: begin
                if (door_hold) begin
                    timer_d = DOOR_RELOAD;
                end else if (timer_q == 8'd0) begin
                    state_d = ST_IDLE;
                end else begin
                    timer_d = timer_q - 8'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                timer_d = 8'd0;
            end
        endcase
    end

    // State registers; moving/door_open are registered decodes of the next state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            floor_q     <= 3'd0;
            dir_up_q    <= 1'b1;
            timer_q     <= 8'd0;
            moving_q    <= 1'b0;
            door_open_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            floor_q     <= floor_d;
            dir_up_q    <= dir_up_d;
            timer_q     <= timer_d;
            moving_q    <= (state_d == ST_MOVING) || (state_d == ST_ARRIVE);
            door_open_q <= (state_d == ST_DOORS);
        end
    end

    assign floor     = floor_q;
    assign dir_up    = dir_up_q;
    assign moving    = moving_q;
    assign door_open = door_open_q;
    // A call placed at the open floor is cleared without reopening the doors.
    assign clr_en    = door_open_q & calls[floor_q];
    assign clr_floor = floor_q;

endmodule

// File: tb/tb_elevator_scheduler.sv
// Scoreboard bench for elevator_scheduler: expected door openings and clears are
// queued when calls are driven and matched as the car serves them.
module tb_elevator_scheduler;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] call_mask;
    logic       door_hold;
    logic [2:0] floor;
    logic       dir_up, moving, door_open, clr_en;
    logic [2:0] clr_floor;

    // Second car with only five floors, used for masking of unused call bits.
    logic [7:0] call_mask5;
    logic [2:0] floor5, clr_floor5;
    logic       dir5, moving5, door5, clr5;

    always #5 clk = ~clk;

    elevator_scheduler u_dut (
        .clk       (clk),
        .reset     (reset),
        .call_mask (call_mask),
        .door_hold (door_hold),
        .floor     (floor),
        .dir_up    (dir_up),
        .moving    (moving),
        .door_open (door_open),
        .clr_en    (clr_en),
        .clr_floor (clr_floor)
    );

    elevator_scheduler #(.NUM_FLOORS(5)) u_dut5 (
        .clk       (clk),
        .reset     (reset),
        .call_mask (call_mask5),
        .door_hold (1'b0),
        .floor     (floor5),
        .dir_up    (dir5),
        .moving    (moving5),
        .door_open (door5),
        .clr_en    (clr5),
        .clr_floor (clr_floor5)
    );

    typedef struct {
        int fl;
        int lat;
        int len;
    } open_exp_t;

    open_exp_t  open_q[$];
    int         clr_q[$];
    int         n_cmp = 0;
    int         n_err = 0;
    int         cyc = 0;
    int         t_ref = 0;
    int         cur_len = 0;
    int         open_start = 0;
    logic       door_prev = 1'b0;
    logic [2:0] floor_prev = 3'd0;
    logic       saw_moving = 1'b0;
    logic       m5_changed = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One clock: sample clr at negedge, model the register-file clear, then monitor.
    task automatic tick();
        logic       ce;
        logic [2:0] cf;
        open_exp_t  e;
        @(negedge clk);
        ce = clr_en;
        cf = clr_floor;
        @(posedge clk);
        #1;
        cyc++;
        if (ce) begin
            call_mask[cf] = 1'b0;
            if (clr_q.size() == 0) check("clr_extra_pending", 32'(clr_q.size()), 32'd1);
            else check("clr_floor", 32'(cf), 32'(clr_q.pop_front()));
        end
        if (moving) saw_moving = 1'b1;
        if (moving && (floor != floor_prev))
            check("dir_on_step", 32'(dir_up), 32'(floor > floor_prev));
        floor_prev = floor;
        if (door_open && !door_prev) begin
            if (open_q.size() == 0) begin
                check("open_extra_pending", 32'(open_q.size()), 32'd1);
            end else begin
                e = open_q.pop_front();
                check("open_floor", 32'(floor), 32'(e.fl));
                check("open_latency", 32'(cyc - t_ref), 32'(e.lat));
                cur_len = e.len;
            end
            open_start = cyc;
        end
        if (!door_open && door_prev) begin
            check("open_len", 32'(cyc - open_start), 32'(cur_len));
            t_ref = cyc;
        end
        door_prev = door_open;
        if (floor5 != 3'd0 || moving5 || door5 || !dir5 || clr5) m5_changed = 1'b1;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while ((call_mask != 8'h00 || moving || door_open) && n < 400) begin
            tick();
            n++;
        end
        check({tag, "_settle"}, 32'(n < 400), 32'd1);
    endtask

    initial begin
        int n;
        reset      = 1'b1;
        call_mask  = 8'h00;
        call_mask5 = 8'h00;
        door_hold  = 1'b0;
        #2 reset = 1'b0;
        #1;
        check("rst_floor", 32'(floor), 32'd0);
        check("rst_dir", 32'(dir_up), 32'd1);
        check("rst_moving", 32'(moving), 32'd0);
        check("rst_door", 32'(door_open), 32'd0);
        check("rst_clr_en", 32'(clr_en), 32'd0);
        check("rst_clr_floor", 32'(clr_floor), 32'd0);
        tick();
        tick();
        reset      = 1'b1;
        call_mask5 = 8'hE0;
        tick();

        // Single call three floors up.
        t_ref = cyc;
        open_q.push_back('{3, 16, 6});
        clr_q.push_back(3);
        call_mask = 8'h08;
        wait_idle("single");
        check("single_floor", 32'(floor), 32'd3);

        // Back down to floor 0.
        t_ref = cyc;
        open_q.push_back('{0, 16, 6});
        clr_q.push_back(0);
        call_mask = 8'h01;
        wait_idle("down");
        check("down_dir", 32'(dir_up), 32'd0);

        // Collective order: floor 1 called while passing floor 2 upward toward 5.
        t_ref = cyc;
        open_q.push_back('{5, 26, 6});
        open_q.push_back('{1, 21, 6});
        clr_q.push_back(5);
        clr_q.push_back(1);
        call_mask = 8'h20;
        n = 0;
        while (floor != 3'd2 && n < 100) begin
            tick();
            n++;
        end
        check("reach_2", 32'(n < 100), 32'd1);
        check("at2_dir", 32'(dir_up), 32'd1);
        check("at2_moving", 32'(moving), 32'd1);
        call_mask = call_mask | 8'h02;
        wait_idle("collective");
        check("coll_floor", 32'(floor), 32'd1);
        check("coll_dir", 32'(dir_up), 32'd0);

        // Door hold at floor 4 for ten cycles.
        t_ref = cyc;
        open_q.push_back('{4, 16, 16});
        clr_q.push_back(4);
        call_mask = 8'h10;
        n = 0;
        while (!door_open && n < 100) begin
            tick();
            n++;
        end
        check("hold_open", 32'(door_open), 32'd1);
        door_hold = 1'b1;
        repeat (10) tick();
        door_hold = 1'b0;
        wait_idle("hold");

        // Go to 6, then call the floor the car is parked at.
        t_ref = cyc;
        open_q.push_back('{6, 11, 6});
        clr_q.push_back(6);
        call_mask = 8'h40;
        wait_idle("to6");
        saw_moving = 1'b0;
        t_ref = cyc;
        open_q.push_back('{6, 1, 6});
        clr_q.push_back(6);
        call_mask = 8'h40;
        wait_idle("here");
        check("here_no_move", 32'(saw_moving), 32'd0);

        // Asynchronous reset while travelling down.
        call_mask = 8'h01;
        repeat (7) tick();
        check("pre_rst_moving", 32'(moving), 32'd1);
        #2 reset = 1'b0;
        #1;
        check("mid_rst_floor", 32'(floor), 32'd0);
        check("mid_rst_dir", 32'(dir_up), 32'd1);
        check("mid_rst_moving", 32'(moving), 32'd0);
        check("mid_rst_door", 32'(door_open), 32'd0);
        check("mid_rst_clr_en", 32'(clr_en), 32'd0);
        call_mask = 8'h00;
        tick();
        tick();
        reset = 1'b1;
        repeat (5) tick();
        check("post_rst_moving", 32'(moving), 32'd0);
        check("post_rst_floor", 32'(floor), 32'd0);

        check("mask5_unchanged", 32'(m5_changed), 32'd0);
        check("mask5_floor", 32'(floor5), 32'd0);
        check("open_q_left", 32'(open_q.size()), 32'd0);
        check("clr_q_left", 32'(clr_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/elevator_scheduler.md
# elevator_scheduler

Sequencing controller for the elevator datapath. Each cycle it reads the pending-call mask from the call register file. It runs a collective (SCAN) policy: it moves the car floor by floor, opens the doors at called floors, and pulses a clear request back to the register file for the served floor. It owns the car position, direction and door state that feed the floor display and the rest of the controller.

## Interface
- NUM_FLOORS, 8, number of served floors (2..8); floor indices are 0..NUM_FLOORS-1.
- TRAVEL_CYCLES, 4, cycles to traverse one floor (1..255).
- DOOR_CYCLES, 6, cycles the doors stay open after the last hold (1..255).

- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset; 0 resets all state immediately.
- call_mask  in  8  pending calls, bit i = call at floor i; bits >= NUM_FLOORS are ignored.
- door_hold  in  1  keypad door-open request; reloads the door timer while in DOORS.
- floor  out  3  current car floor.
- dir_up  out  1  travel direction, 1 = up.
- moving  out  1  high in MOVING and ARRIVE.
- door_open  out  1  high in DOORS.
- clr_en  out  1  clear request for the served call.
- clr_floor  out  3  floor to clear; equals floor.

## Operation
- The FSM has four states: IDLE, MOVING, ARRIVE, DOORS.
- Definitions: above = any call_mask bit with index > floor; below = any bit with index < floor; here = call_mask[floor]. Only bits < NUM_FLOORS count.
- IDLE:
  - here -> DOORS.
  - Otherwise, if (dir_up & above) or (!dir_up & below) -> MOVING, keeping dir.
  - Otherwise, if above -> dir_up=1, MOVING. If below -> dir_up=0, MOVING.
  - Otherwise stay in IDLE.
  - The timer loads TRAVEL_CYCLES-1 on entry to MOVING.
- MOVING:
  - The timer decrements each cycle.
  - In the cycle it is 0, floor increments (dir_up) or decrements, then -> ARRIVE.
- ARRIVE (exactly one cycle, evaluated at the new floor):
  - here -> DOORS.
  - Otherwise, calls ahead in the current direction -> MOVING, timer reloaded.
  - Otherwise -> IDLE. IDLE handles any reversal.
- DOORS:
  - The timer loads DOOR_CYCLES-1 on entry and decrements each cycle.
  - door_hold=1 reloads it to DOOR_CYCLES-1.
  - Timer at 0 with door_hold=0 -> IDLE.
- clr_en = door_open & call_mask[floor], so a call made at the open floor is cleared without reopening.
- Floor saturation: floor never goes below 0 or above NUM_FLOORS-1. A direction with no calls ahead is never entered, so saturation is a safety guard only.
- Simultaneous calls above and below in IDLE: the current direction wins.
- Calls added or dropped mid-travel are honoured at the next ARRIVE evaluation.
- Reset values: state=IDLE, floor=0, dir_up=1, moving=0, door_open=0, clr_en=0, clr_floor=0, timers=0.
- Reset asserted mid-operation returns everything to the reset values asynchronously. No travel resumes after release until a call is seen.

## Timing
- Decision latency: a call sampled in IDLE on edge N gives a state change at edge N (outputs updated after edge N).
- Floor step: each traversed floor costs TRAVEL_CYCLES cycles in MOVING plus 1 cycle in ARRIVE.
- Travel of k floors from IDLE: door_open rises 1 + k*(TRAVEL_CYCLES+1) cycles after the call is first sampled.
- Door dwell: door_open stays high DOOR_CYCLES cycles after the last cycle door_hold was 1 (minimum DOOR_CYCLES cycles total).
- clr_en is combinational from registered state and call_mask. The register file clears the bit at the next edge, so clr_en lasts one cycle per served call.
- All outputs are registered except clr_en.

## Test plan
- Reset: drive reset=0 mid-MOVING -> floor=0, dir_up=1, moving=0, door_open=0, clr_en=0 immediately, without waiting for a clock edge.
- Single call, defaults: idle at floor 0, call_mask=8'h08.
  - door_open rises 16 cycles after the call is first sampled, with floor=3.
  - clr_en=1, clr_floor=3 for one cycle; the bench model clears the bit.
  - IDLE is reached after 6 open cycles.
- Collective order: car at 2 moving up, call_mask=8'h22 (floors 1 and 5).
  - Stops at 5 first; floors 3 and 4 pass without opening.
  - Then reverses to 1; dir_up=0 during the descent.
- Hold: doors open at floor 4, door_hold=1 for 10 cycles -> door_open stays high 10+6 cycles after hold starts.
- Call at current floor: idle at 6, call_mask=8'h40 -> door_open=1 next cycle, moving never asserts, clr_floor=6.
- Masking: NUM_FLOORS=5, call_mask=8'hE0 -> stays IDLE indefinitely with outputs unchanged.
